// File: rtl/instr_fetch_if.sv
// Handshake, program-load and fetch-output bundle between the fetch unit and its environment.
// FETCH_STALL_EN adds the stall input.
interface instr_fetch_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             load_en;
  logic [PC_W-1:0]  load_addr;
  logic [8:0]       load_data;
  logic             branch;
  logic             branch_conditional;
  logic             zero_flag;
`ifdef FETCH_STALL_EN
  logic             stall;
`endif
  logic [8:0]       instruction;
  logic             instr_valid;
  logic [PC_W-1:0]  pc;
  logic             done;
  logic [CNT_W-1:0] retired;

  modport master (
`ifdef FETCH_STALL_EN
    output stall,
`endif
    output start, load_en, load_addr, load_data,
    output branch, branch_conditional, zero_flag,
    input  instruction, instr_valid, pc, done, retired
  );

  modport slave (
`ifdef FETCH_STALL_EN
    input  stall,
`endif
    input  start, load_en, load_addr, load_data,
    input  branch, branch_conditional, zero_flag,
    output instruction, instr_valid, pc, done, retired
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front end: program memory, PC, IR and retired counter under a start/done handshake.
// Optional FETCH_STALL_EN: a stall input freezes fetch while running.
module instr_fetch #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.slave  io_bus
);
  localparam int         DEPTH     = 1 << PC_W;
  localparam logic [8:0] HALT_WORD = 9'b110_000000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_nextState;
  logic [8:0]       r_mem [DEPTH];
  logic [8:0]       r_ir, w_nextIr;
  logic [PC_W-1:0]  r_pc, w_nextPc;
  logic [CNT_W-1:0] r_retired, w_nextRetired;
  logic             r_valid, w_nextValid;
  logic             r_done, w_nextDone;

  logic             w_taken;
  logic             w_halt;
  logic             w_stall;
  logic             w_load;
  logic [PC_W-1:0]  w_offset;
  logic [PC_W-1:0]  w_seqPc;
  logic [8:0]       w_seqWord;
  logic [8:0]       w_word0;

`ifdef FETCH_STALL_EN
  assign w_stall = io_bus.stall;
`else
  assign w_stall = 1'b0;
`endif

  // Next PC is resolved in the same cycle, so a taken branch costs no bubble.
  assign w_taken   = io_bus.branch & (~io_bus.branch_conditional | io_bus.zero_flag);
  assign w_offset  = {{(PC_W-6){r_ir[5]}}, r_ir[5:0]};
  assign w_seqPc   = w_taken ? (r_pc + w_offset) : (r_pc + PC_W'(1));
  assign w_seqWord = r_mem[w_seqPc];
  assign w_word0   = r_mem[0];
  assign w_halt    = (r_ir == HALT_WORD);

  assign w_load = rst_n & io_bus.load_en & (r_state != S_RUN);

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_mem[io_bus.load_addr] <= io_bus.load_data;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextIr      = r_ir;
    w_nextPc      = r_pc;
    w_nextRetired = r_retired;
    w_nextValid   = r_valid;
    w_nextDone    = r_done;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (io_bus.start) begin
          w_nextState   = S_RUN;
          w_nextIr      = w_word0;
          w_nextPc      = '0;
          w_nextRetired = '0;
          w_nextDone    = 1'b0;
          w_nextValid   = 1'b1;
        end
      end
      S_RUN: begin
        if (!w_stall) begin
          // The halt word is not counted as retired.
          if (w_halt) begin
            w_nextState = S_DONE;
            w_nextDone  = 1'b1;
            w_nextValid = 1'b0;
          end else begin
            w_nextPc = w_seqPc;
            w_nextIr = w_seqWord;
            if (r_retired != {CNT_W{1'b1}}) begin
              w_nextRetired = r_retired + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_pc      <= '0;
      r_retired <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_ir      <= w_nextIr;
      r_pc      <= w_nextPc;
      r_retired <= w_nextRetired;
      r_valid   <= w_nextValid;
      r_done    <= w_nextDone;
    end
  end

  assign io_bus.instruction = r_ir;
  assign io_bus.instr_valid = r_valid;
  assign io_bus.pc          = r_pc;
  assign io_bus.done        = r_done;
  assign io_bus.retired     = r_retired;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequencing, branches, PC wrap, load/start gating and reset.
// Stall steps are included when FETCH_STALL_EN is defined.
module tb_instr_fetch;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  instr_fetch_if #(.PC_W(8), .CNT_W(16)) ifc ();

  instr_fetch #(.PC_W(8), .CNT_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock cycle with the given inputs; returns at the following falling edge.
  task automatic applyStimulus(input logic st, input logic le, input logic [7:0] la,
                               input logic [8:0] ld, input logic br, input logic brc,
                               input logic zf);
    ifc.start              = st;
    ifc.load_en            = le;
    ifc.load_addr          = la;
    ifc.load_data          = ld;
    ifc.branch             = br;
    ifc.branch_conditional = brc;
    ifc.zero_flag          = zf;
    @(negedge clk);
  endtask

  task automatic step();
    applyStimulus(1'b0, 1'b0, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic loadWord(input logic [7:0] a, input logic [8:0] d);
    applyStimulus(1'b0, 1'b1, a, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [7:0] ePc, input logic [8:0] eIr,
                            input logic [15:0] eRet, input logic eValid, input logic eDone);
    checkOutput({tag, ".pc"},          32'(ifc.pc),          32'(ePc));
    checkOutput({tag, ".instruction"}, 32'(ifc.instruction), 32'(eIr));
    checkOutput({tag, ".retired"},     32'(ifc.retired),     32'(eRet));
    checkOutput({tag, ".instr_valid"}, 32'(ifc.instr_valid), 32'(eValid));
    checkOutput({tag, ".done"},        32'(ifc.done),        32'(eDone));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
`ifdef FETCH_STALL_EN
    ifc.stall = 1'b0;
`endif
    step();
    step();
    checkState("reset", 8'd0, 9'h000, 16'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Straight-line program ending in the halt word
    loadWord(8'd0, 9'h001);
    loadWord(8'd1, 9'h042);
    loadWord(8'd2, 9'h180);
    checkState("idle_after_load", 8'd0, 9'h000, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    checkState("p1_pc0", 8'd0, 9'h001, 16'd0, 1'b1, 1'b0);
    step();
    checkState("p1_pc1", 8'd1, 9'h042, 16'd1, 1'b1, 1'b0);
    step();
    checkState("p1_pc2", 8'd2, 9'h180, 16'd2, 1'b1, 1'b0);
    step();
    checkState("p1_halt", 8'd2, 9'h180, 16'd2, 1'b0, 1'b1);
    step();
    checkState("p1_done_held", 8'd2, 9'h180, 16'd2, 1'b0, 1'b1);

    // Backward branch by -2 from address 5
    loadWord(8'd2, 9'h001);
    loadWord(8'd3, 9'h001);
    loadWord(8'd4, 9'h001);
    loadWord(8'd5, 9'h1BE);
    loadWord(8'd6, 9'h180);
    applyStimulus(1'b1, 1'b0, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    checkState("p2_pc0", 8'd0, 9'h001, 16'd0, 1'b1, 1'b0);
    step();
    step();
    step();
    step();
    checkState("p2_pc4", 8'd4, 9'h001, 16'd4, 1'b1, 1'b0);
`ifdef FETCH_STALL_EN
    ifc.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checkState("p2_stall", 8'd4, 9'h001, 16'd4, 1'b1, 1'b0);
    end
    ifc.stall = 1'b0;
`endif
    step();
    checkState("p2_pc5", 8'd5, 9'h1BE, 16'd5, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 9'd0, 1'b1, 1'b0, 1'b0);
    checkState("p2_br_back", 8'd3, 9'h001, 16'd6, 1'b1, 1'b0);
    step();
    step();
    step();
    checkState("p2_fallthru", 8'd6, 9'h180, 16'd9, 1'b1, 1'b0);
    step();
    checkState("p2_halt", 8'd6, 9'h180, 16'd9, 1'b0, 1'b1);

    // Conditional branch +4 at address 1, not taken then taken
    loadWord(8'd1, 9'h1C4);
    loadWord(8'd2, 9'h180);
    loadWord(8'd5, 9'h180);
    applyStimulus(1'b1, 1'b0, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    step();
    checkState("p3_pc1", 8'd1, 9'h1C4, 16'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 9'd0, 1'b1, 1'b1, 1'b0);
    checkState("p3_brz_nt", 8'd2, 9'h180, 16'd2, 1'b1, 1'b0);
    step();
    checkState("p3_halt", 8'd2, 9'h180, 16'd2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    checkState("p4_restart", 8'd0, 9'h001, 16'd0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 8'd0, 9'd0, 1'b1, 1'b1, 1'b1);
    checkState("p4_brz_t", 8'd5, 9'h180, 16'd2, 1'b1, 1'b0);
    step();
    checkState("p4_halt", 8'd5, 9'h180, 16'd2, 1'b0, 1'b1);

    // PC wrap in both directions, then BRZ +0 with zero clear falls through
    loadWord(8'd1, 9'h1C0);
    loadWord(8'd2, 9'h1BC);
    loadWord(8'd3, 9'h180);
    loadWord(8'd254, 9'h001);
    loadWord(8'd255, 9'h001);
    applyStimulus(1'b1, 1'b0, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkState("p5_pc2", 8'd2, 9'h1BC, 16'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 9'd0, 1'b1, 1'b0, 1'b0);
    checkState("p5_wrap_down", 8'd254, 9'h001, 16'd3, 1'b1, 1'b0);
    step();
    checkState("p5_pc255", 8'd255, 9'h001, 16'd4, 1'b1, 1'b0);
    step();
    checkState("p5_wrap_up", 8'd0, 9'h001, 16'd5, 1'b1, 1'b0);
    step();
    checkState("p5_brz0", 8'd1, 9'h1C0, 16'd6, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 9'd0, 1'b1, 1'b1, 1'b0);
    checkState("p5_brz0_fall", 8'd2, 9'h1BC, 16'd7, 1'b1, 1'b0);
    step();
    checkState("p5_pc3", 8'd3, 9'h180, 16'd8, 1'b1, 1'b0);
    step();
    checkState("p5_halt", 8'd3, 9'h180, 16'd8, 1'b0, 1'b1);

    // Load and start ignored in RUN, reset mid-run, write-with-start ordering
    loadWord(8'd1, 9'h001);
    loadWord(8'd2, 9'h001);
    applyStimulus(1'b1, 1'b0, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd0, 9'h1FF, 1'b0, 1'b0, 1'b0);
    checkState("p6_load_in_run", 8'd1, 9'h001, 16'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    checkState("p6_start_in_run", 8'd2, 9'h001, 16'd2, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    checkState("p6_reset_run", 8'd0, 9'h000, 16'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'd0, 9'h055, 1'b0, 1'b0, 1'b0);
    checkState("p6_start_old_word", 8'd0, 9'h001, 16'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    checkState("p6_new_word", 8'd0, 9'h055, 16'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
